// File: rtl/tx_bit_timer_pkg.sv
// rtl/tx_bit_timer_pkg.sv - shared FSM state encoding and default widths for tx_bit_timer
package tx_bit_timer_pkg;

  localparam int DEF_CNT_BITS = 4;
  localparam int DEF_BIT_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BIT  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/tx_bit_timer_if.sv
// rtl/tx_bit_timer_if.sv - control/config inputs and strobe outputs of tx_bit_timer
interface tx_bit_timer_if #(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_BIT_BITS = 4
);

  logic                    start;
  logic                    abort;
  logic [NUM_CNT_BITS-1:0] bit_period;
  logic [NUM_BIT_BITS-1:0] num_bits;
  logic                    busy;
  logic                    load_strobe;
  logic                    shift_strobe;
  logic [NUM_BIT_BITS-1:0] bit_index;
  logic                    packet_done;

  modport master (
    output start, abort, bit_period, num_bits,
    input  busy, load_strobe, shift_strobe, bit_index, packet_done
  );

  modport slave (
    input  start, abort, bit_period, num_bits,
    output busy, load_strobe, shift_strobe, bit_index, packet_done
  );

endinterface

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable down-counter; tc flags the cycle the count equals 1
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_out,
  output logic             tc
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (load) begin
      count_out <= load_val;
    end else if (enable) begin
      count_out <= count_out - WIDTH'(1);
    end
  end

  assign tc = (count_out == WIDTH'(1));

endmodule

// File: rtl/tx_bit_timer.sv
// rtl/tx_bit_timer.sv - packet bit timer: load pulse, per-bit shift pulses, done pulse
module tx_bit_timer
  import tx_bit_timer_pkg::*;
#(
  parameter int NUM_CNT_BITS = DEF_CNT_BITS,
  parameter int NUM_BIT_BITS = DEF_BIT_BITS
) (
  input logic           clk,
  input logic           n_rst,
  tx_bit_timer_if.slave bus
);

  state_t                  state;
  state_t                  state_nxt;
  logic [NUM_CNT_BITS-1:0] period_in;
  logic [NUM_CNT_BITS-1:0] period_q;
  logic [NUM_CNT_BITS-1:0] cnt_load_val;
  logic [NUM_CNT_BITS-1:0] cnt;
  logic [NUM_BIT_BITS-1:0] nbits_q;
  logic [NUM_BIT_BITS-1:0] bit_index_q;
  logic                    cnt_en;
  logic                    cnt_load;
  logic                    cnt_tc;
  logic                    last_bit;

  // A period of 0 behaves as 1 so the counter still hits its terminal count.
  assign period_in    = (bus.bit_period == '0) ? NUM_CNT_BITS'(1) : bus.bit_period;
  assign cnt_load_val = (state == LOAD) ? period_in : period_q;
  assign cnt_en       = (state == BIT);
  assign cnt_load     = (state == LOAD) || ((state == BIT) && cnt_tc);
  assign last_bit     = (bit_index_q == nbits_q - NUM_BIT_BITS'(1));

  down_counter #(
    .WIDTH(NUM_CNT_BITS)
  ) u_period (
    .clk      (clk),
    .n_rst    (n_rst),
    .enable   (cnt_en),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .count_out(cnt),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start && !bus.abort) state_nxt = LOAD;
      LOAD: begin
        if (bus.abort)                state_nxt = IDLE;
        else if (bus.num_bits == '0)  state_nxt = DONE;
        else                          state_nxt = BIT;
      end
      BIT: begin
        if (bus.abort)                state_nxt = IDLE;
        else if (cnt_tc && last_bit)  state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration is captured only in LOAD; later input changes never reach the timing.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      period_q    <= '0;
      nbits_q     <= '0;
      bit_index_q <= '0;
    end else if (state == LOAD) begin
      period_q    <= period_in;
      nbits_q     <= bus.num_bits;
      bit_index_q <= '0;
    end else if ((state == BIT) && cnt_tc) begin
      bit_index_q <= bit_index_q + NUM_BIT_BITS'(1);
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.load_strobe  = (state == LOAD);
  assign bus.shift_strobe = (state == BIT) && cnt_tc;
  assign bus.packet_done  = (state == DONE);
  assign bus.bit_index    = bit_index_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_tx_bit_timer.sv
// tb/tb_tx_bit_timer.sv - scoreboard bench for tx_bit_timer with directed packets
module tb_tx_bit_timer;

  typedef struct {
    int cyc;
    int kind;
    int idx;
  } ev_t;

  logic clk = 1'b0;
  logic n_rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;
  ev_t  sb[$];

  tx_bit_timer_if #(.NUM_CNT_BITS(4), .NUM_BIT_BITS(4)) bus ();

  tx_bit_timer #(
    .NUM_CNT_BITS(4),
    .NUM_BIT_BITS(4)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse the DUT shows is matched against the next expected event.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  k;
    if (bus.busy) busy_cnt++;
    if (bus.load_strobe || bus.shift_strobe || bus.packet_done) begin
      k = bus.load_strobe ? 0 : (bus.shift_strobe ? 1 : 2);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse actual kind=%0d cycle=%0d required no pulse", k, cyc);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.kind != k || (e.idx >= 0 && e.idx != int'(bus.bit_index))) begin
          failures++;
          $display("FAIL pulse actual kind=%0d cycle=%0d idx=%0d required kind=%0d cycle=%0d idx=%0d",
                   k, cyc, bus.bit_index, e.kind, e.cyc, e.idx);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},  int'(bus.busy), 0);
    check({tag, "_load"},  int'(bus.load_strobe), 0);
    check({tag, "_shift"}, int'(bus.shift_strobe), 0);
    check({tag, "_done"},  int'(bus.packet_done), 0);
    check({tag, "_index"}, int'(bus.bit_index), 0);
  endtask

  // Cycle k of a packet is observed at the negedge where cyc == base + k.
  task automatic push_packet(input int base, input int p, input int n,
                             input int nshift, input bit with_done);
    ev_t e;
    int  pe;
    pe = (p == 0) ? 1 : p;
    e.cyc = base + 1; e.kind = 0; e.idx = -1;
    sb.push_back(e);
    for (int k = 1; k <= nshift; k++) begin
      e.cyc = base + 1 + k * pe; e.kind = 1; e.idx = k - 1;
      sb.push_back(e);
    end
    if (with_done) begin
      e.cyc = base + 2 + n * pe; e.kind = 2; e.idx = n;
      sb.push_back(e);
    end
  endtask

  task automatic launch(input int p, input int n, input int nshift, input bit with_done);
    bus.bit_period = 4'(p);
    bus.num_bits   = 4'(n);
    push_packet(cyc, p, n, nshift, with_done);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pending"}, sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int base;
    n_rst          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.bit_period = '0;
    bus.num_bits   = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    n_rst = 1'b1;
    @(negedge clk);

    busy_cnt = 0;
    launch(4, 8, 8, 1'b1);
    wait_drain("p4n8", 60);
    check("p4n8_busy_cycles", busy_cnt, 34);
    check("p4n8_hold_index", int'(bus.bit_index), 8);

    launch(0, 3, 3, 1'b1);
    wait_drain("p0n3", 20);

    launch(4, 0, 0, 1'b1);
    wait_drain("n0", 20);
    check("n0_index", int'(bus.bit_index), 0);

    launch(4, 8, 2, 1'b0);
    repeat (11) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_index", int'(bus.bit_index), 2);
    wait_drain("abort", 10);

    launch(4, 3, 3, 1'b1);
    repeat (5) @(negedge clk);
    bus.bit_period = 4'd2;
    bus.num_bits   = 4'd1;
    wait_drain("cfg_change", 30);

    bus.bit_period = 4'd1;
    bus.num_bits   = 4'd1;
    base = cyc;
    push_packet(base, 1, 1, 1, 1'b1);
    push_packet(base + 4, 1, 1, 1, 1'b1);
    bus.start = 1'b1;
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    wait_drain("held_start", 20);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_prio_busy", int'(bus.busy), 0);
    @(negedge clk);
    check("abort_prio_busy2", int'(bus.busy), 0);

    launch(4, 8, 2, 1'b0);
    repeat (9) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_quiet("midrst");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    launch(4, 2, 2, 1'b1);
    wait_drain("after_rst", 30);
    check("after_rst_index", int'(bus.bit_index), 2);

    launch(15, 15, 15, 1'b1);
    wait_drain("max", 300);
    check("max_index", int'(bus.bit_index), 15);
    check("max_busy", int'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_bit_timer.md
TX_BIT_TIMER -- requirements
Module: tx_bit_timer

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 4, giving the width of the bit-period field.
REQ-002 SHALL have parameter NUM_BIT_BITS, default 4, giving the width of the bit-count field.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request to begin one packet; honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the packet in progress.
REQ-007 SHALL have port bit_period  input  NUM_CNT_BITS  clocks per bit.
REQ-008 SHALL have port num_bits  input  NUM_BIT_BITS  bits per packet.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port load_strobe  output  1  one-cycle pulse; the transmitter loads its shift register.
REQ-011 SHALL have port shift_strobe  output  1  one-cycle pulse at the end of each bit period.
REQ-012 SHALL have port bit_index  output  NUM_BIT_BITS  bits already shifted in the current packet.
REQ-013 SHALL have port packet_done  output  1  one-cycle pulse after the last shift.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, BIT and DONE.
REQ-015 IDLE SHALL go to LOAD on start=1 and abort=0; start SHALL be ignored in all other states.
REQ-016 LOAD SHALL last one cycle, assert load_strobe, sample bit_period and num_bits into internal registers, and clear bit_index to 0.
REQ-017 After LOAD, the FSM SHALL go to BIT if the sampled num_bits is not 0, and to DONE otherwise (no shift_strobe issued).
REQ-018 The configuration inputs SHALL be ignored outside LOAD; changes during a packet SHALL have no effect.
REQ-019 In BIT, the period down-counter SHALL start at P, decrement each cycle, and assert shift_strobe on the cycle it equals 1.
REQ-020 On that same cycle the period counter SHALL reload with P and bit_index SHALL increment.
REQ-021 A sampled bit_period of 0 SHALL be treated as P=1, giving shift_strobe every cycle.
REQ-022 The shift_strobe that brings bit_index to N SHALL move the FSM to DONE.
REQ-023 DONE SHALL last one cycle, assert packet_done, then return to IDLE; bit_index SHALL hold N until the next LOAD.
REQ-024 Timing SHALL be, for start high at edge 0: load_strobe in cycle 1, k-th shift_strobe in cycle 1+k*P for k=1..N, packet_done in cycle 2+N*P.
REQ-025 A start held high through DONE SHALL begin a new LOAD on the cycle after DONE (IDLE then LOAD), not back-to-back.
REQ-026 abort=1 in LOAD, BIT or DONE SHALL force IDLE on the next edge, with no further strobes and no packet_done.
REQ-027 abort SHALL take priority over start in IDLE.
REQ-028 All outputs SHALL decode only from registered state and counters, with no combinational path from any input to any output.
REQ-029 The period counter SHALL be NUM_CNT_BITS wide and the bit counter NUM_BIT_BITS wide; maximum values (P=2^NUM_CNT_BITS-1, N=2^NUM_BIT_BITS-1) SHALL work without overflow.

Reset
REQ-030 n_rst=0 SHALL immediately force state IDLE, busy=0, load_strobe=0, shift_strobe=0, packet_done=0, bit_index=0, and both internal counters to 0.
REQ-031 Reset asserted mid-packet SHALL discard the packet; the first cycle after release SHALL be IDLE with no pulse outputs.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, LOAD, BIT, DONE) and the default widths.
REQ-033 The period timing SHALL be one sub-module, down_counter: loadable, parameterised width, with enable, load, load_val, count_out and a terminal-count flag.
REQ-034 The bit counter and FSM SHALL be implemented in tx_bit_timer.

Verification
REQ-035 P=4, N=8, start pulse at cycle 0 -> load_strobe at 1, shift_strobe at 5,9,...,33, packet_done at 34, busy high in cycles 1-34.
REQ-036 bit_period=0, N=3 -> shift_strobe in cycles 2,3,4, packet_done at 5.
REQ-037 num_bits=0 -> load_strobe at 1, packet_done at 2, no shift_strobe.
REQ-038 P=4, N=8, abort at cycle 12 -> last shift_strobe at 9, IDLE at 13, no packet_done, bit_index=2.
REQ-039 Change bit_period from 4 to 2 in cycle 6 during a P=4 packet -> strobe spacing stays 4 cycles.
REQ-040 n_rst low at cycle 10 of a packet, start at the first cycle after release -> all outputs 0 during reset, then a fresh packet with nominal timing.
